// File: rtl/barrett_precomp.sv
// Barrett setup stage: from modulus m computes m_bl and mu = floor(2^(2*m_bl)/m)
// with a one-bit-per-cycle restoring divider. Optional result cache: BARRETT_PRECOMP_CACHE_EN.
module barrett_precomp #(
    parameter int DATA_LENGTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] m_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] m_o,
    output logic [DATA_LENGTH-1:0] m_bl_o,
    output logic [DATA_LENGTH-1:0] mu_o,
    output logic                   err_o
);

    localparam int BL_W  = $clog2(DATA_LENGTH + 1);
    localparam int CNT_W = BL_W + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BITLEN = 2'd1;
    localparam logic [1:0] DIVIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]             state;
    logic [BL_W-1:0]        bl_reg;
    logic [BL_W-1:0]        bit_len;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_LENGTH:0]   rem;
    logic [DATA_LENGTH:0]   rem_shift;
    logic [DATA_LENGTH:0]   rem_sub;
    logic [DATA_LENGTH-1:0] quot;
    logic [DATA_LENGTH-1:0] quot_next;
    logic                   m_err;
    logic                   d_bit;
    logic                   q_bit;

`ifdef BARRETT_PRECOMP_CACHE_EN
    logic                   cache_valid;
    logic [DATA_LENGTH-1:0] cache_m;
    logic [DATA_LENGTH-1:0] cache_bl;
    logic [DATA_LENGTH-1:0] cache_mu;
    logic                   cache_hit;
`endif

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    // m_o holds the accepted modulus, so it doubles as the working operand.
    always_comb begin
        bit_len = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (m_o[i]) begin
                bit_len = BL_W'(i + 1);
            end
        end
    end

    assign m_err     = (m_o == '0) || m_o[DATA_LENGTH-1];
    // The dividend 2^(2*m_bl) contributes its only set bit on the first step.
    assign d_bit     = (cnt == {bl_reg, 1'b0});
    assign rem_shift = {rem[DATA_LENGTH-1:0], d_bit};
    assign q_bit     = (rem_shift >= {1'b0, m_o});
    assign rem_sub   = rem_shift - {1'b0, m_o};
    assign quot_next = {quot[DATA_LENGTH-2:0], q_bit};

`ifdef BARRETT_PRECOMP_CACHE_EN
    assign cache_hit = cache_valid && (cache_m == m_o);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            m_o    <= '0;
            m_bl_o <= '0;
            mu_o   <= '0;
            err_o  <= 1'b0;
            bl_reg <= '0;
            cnt    <= '0;
            rem    <= '0;
            quot   <= '0;
`ifdef BARRETT_PRECOMP_CACHE_EN
            cache_valid <= 1'b0;
            cache_m     <= '0;
            cache_bl    <= '0;
            cache_mu    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        m_o   <= m_i;
                        state <= BITLEN;
                    end
                end
                BITLEN: begin
                    if (m_err) begin
                        m_bl_o <= '0;
                        mu_o   <= '0;
                        err_o  <= 1'b1;
                        state  <= DONE;
`ifdef BARRETT_PRECOMP_CACHE_EN
                    end else if (cache_hit) begin
                        m_bl_o <= cache_bl;
                        mu_o   <= cache_mu;
                        err_o  <= 1'b0;
                        state  <= DONE;
`endif
                    end else begin
                        err_o  <= 1'b0;
                        bl_reg <= bit_len;
                        cnt    <= {bit_len, 1'b0};
                        rem    <= '0;
                        quot   <= '0;
                        state  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem  <= q_bit ? rem_sub : rem_shift;
                    quot <= quot_next;
                    if (cnt == '0) begin
                        m_bl_o <= DATA_LENGTH'(bl_reg);
                        mu_o   <= quot_next;
                        state  <= DONE;
`ifdef BARRETT_PRECOMP_CACHE_EN
                        cache_valid <= 1'b1;
                        cache_m     <= m_o;
                        cache_bl    <= DATA_LENGTH'(bl_reg);
                        cache_mu    <= quot_next;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_precomp.sv
// Self-checking bench for barrett_precomp: scoreboard of expected (m, m_bl, mu, err, latency).
// Honours BARRETT_PRECOMP_CACHE_EN when predicting latency.
module tb_barrett_precomp;

    localparam int DL = 64;
`ifdef BARRETT_PRECOMP_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        logic [DL-1:0] m;
        logic [DL-1:0] bl;
        logic [DL-1:0] mu;
        logic          err;
        int            lat;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DL-1:0] m_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DL-1:0] m_o;
    logic [DL-1:0] m_bl_o;
    logic [DL-1:0] mu_o;
    logic          err_o;

    exp_t          sb[$];
    int            checkCount = 0;
    int            failCount  = 0;
    logic          cacheValid = 1'b0;
    logic [DL-1:0] cacheM     = '0;

    barrett_precomp #(.DATA_LENGTH(DL)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .m_i         (m_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .m_o         (m_o),
        .m_bl_o      (m_bl_o),
        .mu_o        (mu_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bit length by shifting, mu by wide division.
    function automatic exp_t model(input logic [DL-1:0] m);
        exp_t e;
        int bl;
        logic [127:0] num;
        logic [127:0] q;
        bl = 0;
        while (bl < DL && (m >> bl) != '0) bl++;
        e.m   = m;
        e.err = (m == '0) || (bl == DL);
        if (e.err) begin
            e.bl  = '0;
            e.mu  = '0;
            e.lat = 2;
        end else begin
            num   = 128'd1 << (2 * bl);
            q     = num / {64'd0, m};
            e.bl  = DL'(bl);
            e.mu  = q[DL-1:0];
            e.lat = (CACHE_EN && cacheValid && cacheM == m) ? 2 : 2 * bl + 3;
            cacheValid = 1'b1;
            cacheM     = m;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [DL-1:0] m, input int hold);
        exp_t e;
        int lat;
        in_valid_i = 1'b1;
        m_i        = m;
        checkOutput("in_ready_idle", in_ready_o, 1);
        sb.push_back(model(m));
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        m_i        = '1;
        lat        = 1;
        while (!out_valid_o && lat < 300) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!out_valid_o) begin
            checkOutput("timeout", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("latency", lat, e.lat);
        checkOutput("m_o", m_o, e.m);
        checkOutput("m_bl", m_bl_o, e.bl);
        checkOutput("mu", mu_o, e.mu);
        checkOutput("err", err_o, e.err);
        for (int h = 0; h < hold; h++) begin
            in_valid_i = 1'b1;
            m_i        = 64'd5;
            @(posedge clk_i); #1;
            checkOutput("hold_valid", out_valid_o, 1);
            checkOutput("hold_ready", in_ready_o, 0);
            checkOutput("hold_m", m_o, e.m);
            checkOutput("hold_bl", m_bl_o, e.bl);
            checkOutput("hold_mu", mu_o, e.mu);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        checkOutput("valid_drop", out_valid_o, 0);
        checkOutput("ready_back", in_ready_o, 1);
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        m_i         = '0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_in_ready", in_ready_o, 1);
        checkOutput("rst_out_valid", out_valid_o, 0);
        checkOutput("rst_m", m_o, 0);
        checkOutput("rst_bl", m_bl_o, 0);
        checkOutput("rst_mu", mu_o, 0);
        checkOutput("rst_err", err_o, 0);
        rst_i = 1'b0;

        applyStimulus(64'd3, 0);
        applyStimulus(64'd12289, 0);
        applyStimulus(64'd1, 0);
        applyStimulus(64'd0, 0);
        applyStimulus(64'h8000_0000_0000_0000, 0);
        applyStimulus(64'd1000003, 0);
        applyStimulus(64'd7, 10);

        // Abort a division mid-flight with reset.
        in_valid_i = 1'b1;
        m_i        = 64'd12289;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("busy_ready", in_ready_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        cacheValid = 1'b0;
        checkOutput("abort_valid", out_valid_o, 0);
        checkOutput("abort_ready", in_ready_o, 1);
        checkOutput("abort_m", m_o, 0);
        checkOutput("abort_bl", m_bl_o, 0);
        checkOutput("abort_mu", mu_o, 0);
        checkOutput("abort_err", err_o, 0);
        applyStimulus(64'd3, 0);

        applyStimulus(64'd12289, 0);
        applyStimulus(64'd12289, 0);
        applyStimulus(64'd3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
